// File: rtl/sos_pkg.sv
// sos_pkg: sample format and pacer state shared by the SOS filter input path.
package sos_pkg;
  localparam int SOS_NDINT = 3;
  localparam int SOS_NDFRAC = 22;
  typedef logic signed [SOS_NDINT-1:-SOS_NDFRAC] sos_sample_t;
  typedef enum logic {PACE_IDLE, PACE_GAP} pace_state_t;
endpackage

// File: rtl/sos_sample_fifo.sv
// sos_sample_fifo: synchronous FIFO; flush and reset both clear it and win over push/pop.
module sos_sample_fifo import sos_pkg::*; #(
  parameter int W = SOS_NDINT + SOS_NDFRAC,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_head,
  output logic [LW-1:0] o_level
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_level;
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop) r_rd <= r_rd + AW'(1);
      r_level <= r_level + LW'(i_push) - LW'(i_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && !i_flush && i_push) r_mem[r_wr] <= i_data;
  end
  assign o_head = r_mem[r_rd];
  assign o_level = r_level;
endmodule

// File: rtl/sos_sample_feeder.sv
// sos_sample_feeder: buffers upstream samples and paces them out as one-clock
// dv_out strobes at least MIN_GAP clocks apart for the SOS filter input.
module sos_sample_feeder import sos_pkg::*; #(
  parameter int Ndint = SOS_NDINT,
  parameter int Ndfrac = SOS_NDFRAC,
  parameter int DEPTH = 8,
  parameter int MIN_GAP = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     run,
  input  logic                     s_valid,
  input  logic [Ndint+Ndfrac-1:0]  s_data,
  output logic                     s_ready,
  output logic                     dv_out,
  output logic [Ndint+Ndfrac-1:0]  d_out,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     underrun
);
  localparam int W = Ndint + Ndfrac;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(MIN_GAP + 1);
  pace_state_t r_state;
  logic [GW-1:0] r_gap;
  logic r_armed, r_s_ready, r_dv, r_underrun;
  logic [W-1:0] r_d;
  logic w_push, w_pop;
  logic [W-1:0] w_head;
  logic [LW-1:0] w_level, w_level_next;
  assign w_push = s_valid && r_s_ready && !flush;
  // pop decision looks only at the registered level, so a push into an empty FIFO waits a clock
  assign w_pop = (r_state == PACE_IDLE) && run && (w_level != '0) && !flush;
  assign w_level_next = w_level + LW'(w_push) - LW'(w_pop);
  sos_sample_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .i_flush(flush),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_data(s_data),
    .o_head(w_head),
    .o_level(w_level)
  );
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_state <= PACE_IDLE;
      r_gap <= '0;
      r_armed <= 1'b0;
      r_s_ready <= 1'b0;
      r_dv <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_s_ready <= w_level_next < LW'(DEPTH);
      r_dv <= w_pop;
      if (w_pop) r_armed <= 1'b1;
      if (r_armed && r_state == PACE_IDLE && run && w_level == '0) r_underrun <= 1'b1;
      if (r_state == PACE_IDLE) begin
        if (w_pop && MIN_GAP > 1) begin
          r_state <= PACE_GAP;
          r_gap <= GW'(MIN_GAP - 1);
        end
      end else begin
        r_gap <= r_gap - GW'(1);
        if (r_gap == GW'(1)) r_state <= PACE_IDLE;
      end
    end
  end
  // d_out survives flush so the filter input keeps its last sample
  always_ff @(posedge clk) begin
    if (!rst_n) r_d <= '0;
    else if (w_pop) r_d <= w_head;
  end
  assign s_ready = r_s_ready;
  assign dv_out = r_dv;
  assign d_out = r_d;
  assign fifo_level = w_level;
  assign underrun = r_underrun;
endmodule

// File: tb/tb_sos_sample_feeder.sv
// tb_sos_sample_feeder: scoreboard bench for the feeder (MIN_GAP=5 and MIN_GAP=1 instances).
module tb_sos_sample_feeder;
  import sos_pkg::*;
  localparam int W = SOS_NDINT + SOS_NDFRAC;
  logic clk = 0, rst_n = 0;
  logic flush = 0, run = 0, s_valid = 0, flush1 = 0, run1 = 0, s_valid1 = 0;
  logic [W-1:0] s_data = '0, s_data1 = '0, d_out, d_out1;
  logic s_ready, dv_out, underrun, s_ready1, dv_out1, underrun1;
  logic [3:0] fifo_level, fifo_level1;
  int n_tests = 0, n_fail = 0, cyc = 0, lvl1_max = 0;
  logic [W-1:0] q0[$], q1[$];
  int st0[$], st1[$];

  sos_sample_feeder #(.DEPTH(8), .MIN_GAP(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .run(run), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .dv_out(dv_out), .d_out(d_out), .fifo_level(fifo_level), .underrun(underrun)
  );
  sos_sample_feeder #(.DEPTH(8), .MIN_GAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .run(run1), .s_valid(s_valid1), .s_data(s_data1),
    .s_ready(s_ready1), .dv_out(dv_out1), .d_out(d_out1), .fifo_level(fifo_level1), .underrun(underrun1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dv_out) begin
      st0.push_back(cyc);
      if (q0.size() == 0) check("strobe0_unexpected", 1, 0);
      else check("d_out0", d_out, q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && int'(fifo_level1) > lvl1_max) lvl1_max = int'(fifo_level1);
    if (dv_out1) begin
      st1.push_back(cyc);
      if (q1.size() == 0) check("strobe1_unexpected", 1, 0);
      else check("d_out1", d_out1, q1.pop_front());
    end
  end

  // holds s_valid until accepted; hs = edge count at which the handshake happens
  task automatic send(input bit u, input logic [W-1:0] d, output int hs);
    bit ok = 0;
    hs = -1;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (u) begin s_valid1 = 1; s_data1 = d; ok = s_ready1 && !flush1; end
      else begin s_valid = 1; s_data = d; ok = s_ready && !flush; end
      if (ok) begin
        if (u) q1.push_back(d); else q0.push_back(d);
        hs = cyc + 1;
      end
      @(negedge clk);
    end
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic drain(input bit u, input int bound);
    int i = 0;
    while ((u ? q1.size() : q0.size()) != 0 && i < bound) begin
      @(negedge clk);
      i++;
    end
    if (i >= bound) check("drain_timeout", 0, 1);
  endtask

  task automatic do_flush();
    flush = 1;
    @(negedge clk);
    flush = 0;
  endtask

  initial begin
    int hs, hs0, i;
    // reset with s_valid held high
    s_valid = 1;
    s_valid1 = 1;
    repeat (4) @(negedge clk);
    check("rst_dv", dv_out, 0);
    check("rst_dout", d_out, 0);
    check("rst_ready", s_ready, 0);
    check("rst_level", fifo_level, 0);
    check("rst_underrun", underrun, 0);
    check("rst_level1", fifo_level1, 0);
    rst_n = 1;
    @(negedge clk);
    check("rel_ready", s_ready, 1);
    check("rel_level", fifo_level, 0);
    check("rel_ready1", s_ready1, 1);
    s_valid = 0;
    s_valid1 = 0;

    // pacing, back-to-back pushes
    run = 1;
    repeat (3) @(negedge clk);
    check("pre_underrun", underrun, 0);
    st0.delete();
    send(0, 25'h0100000, hs0);
    send(0, 25'h0200000, hs);
    send(0, 25'h0300000, hs);
    s_valid = 0;
    check("pace_b2b", hs - hs0, 2);
    drain(0, 40);
    check("pace_n", st0.size(), 3);
    if (st0.size() == 3) begin
      check("pace_lat", st0[0] - hs0, 1);
      check("pace_gap1", st0[1] - st0[0], 5);
      check("pace_gap2", st0[2] - st0[1], 5);
    end
    repeat (8) @(negedge clk);
    check("pace_underrun", underrun, 1);
    do_flush();
    check("fl0_underrun", underrun, 0);
    check("fl0_ready", s_ready, 0);
    @(negedge clk);
    check("fl0_ready_back", s_ready, 1);

    // underrun timing after two samples
    st0.delete();
    repeat (3) @(negedge clk);
    check("u_pre", underrun, 0);
    send(0, 25'h1234567, hs);
    send(0, 25'h0abcdef, hs);
    s_valid = 0;
    i = 0;
    while (st0.size() < 2 && i < 30) begin @(negedge clk); i++; end
    if (st0.size() < 2) check("u_strobe_timeout", 0, 1);
    else begin
      while (cyc < st0[1] + 4) @(negedge clk);
      check("u_before_slot", underrun, 0);
      @(negedge clk);
      check("u_set", underrun, 1);
      repeat (10) @(negedge clk);
      check("u_sticky", underrun, 1);
    end
    do_flush();
    check("u_flush", underrun, 0);

    // flush mid-gap with level 5
    run = 0;
    for (int k = 0; k < 6; k++) send(0, W'(32'h11111 * (k + 1)), hs);
    s_valid = 0;
    check("f_level6", fifo_level, 6);
    run = 1;
    @(negedge clk);
    @(negedge clk);
    check("f_level5", fifo_level, 5);
    flush = 1;
    s_valid = 1;
    s_data = 25'h1555555;
    @(negedge clk);
    q0.delete();
    flush = 0;
    s_valid = 0;
    check("f_level", fifo_level, 0);
    check("f_dv", dv_out, 0);
    check("f_ready", s_ready, 0);
    check("f_dout_held", d_out, 32'h11111);
    @(negedge clk);
    check("f_ready_back", s_ready, 1);
    st0.delete();
    send(0, 25'h0777777, hs);
    s_valid = 0;
    drain(0, 10);
    if (st0.size() > 0) check("f_lat", st0[0] - hs, 1);
    else check("f_no_strobe", 0, 1);

    // full FIFO, 9th offered while full
    repeat (6) @(negedge clk);
    do_flush();
    run = 0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) send(0, W'(32'h20000 + k), hs);
    check("full_level", fifo_level, 8);
    check("full_ready", s_ready, 0);
    s_data = 25'h0099999;
    repeat (2) @(negedge clk);
    check("full_hold", fifo_level, 8);
    st0.delete();
    run = 1;
    send(0, 25'h0099999, hs);
    s_valid = 0;
    if (st0.size() > 0) check("full_accept", hs - st0[0], 1);
    else check("full_no_strobe", 0, 1);
    drain(0, 80);
    check("full_n", st0.size(), 9);

    // MIN_GAP=1 instance streams every clock
    run1 = 1;
    st1.delete();
    lvl1_max = 0;
    for (int k = 0; k < 4; k++) send(1, W'(32'h30000 + k), hs);
    s_valid1 = 0;
    drain(1, 20);
    check("g1_n", st1.size(), 4);
    if (st1.size() == 4)
      for (int k = 1; k < 4; k++) check("g1_consec", st1[k] - st1[k-1], 1);
    check("g1_lvl_max", lvl1_max, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
